// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier among N requesters.
// Latency: req->grant 2 cycles; grant->rsp_valid 2 + multiplier latency + 1 cycles.
// Backpressure: a request is a level held until grant; all other requests wait in IDLE.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int W       = 3,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*W-1:0]     a_bus,
  input  logic [N*W-1:0]     b_bus,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       rsp_valid,
  output logic [2*W-1:0]     rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic [W-1:0]       m_a,
  output logic [W-1:0]       m_b,
  output logic               m_init,
  input  logic [2*W-1:0]     m_result,
  input  logic               m_done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]     state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  win_q, win_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   m_a_q, m_a_d;
  logic [W-1:0]   m_b_q, m_b_d;
  logic           m_init_q, m_init_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0] rsp_result_q, rsp_result_d;
  logic           rsp_err_q, rsp_err_d;
  logic           busy_q, busy_d;

  logic           pick_vld;
  logic [IW-1:0]  pick_idx;
  logic [CW-1:0]  cnt_inc;

  // Winner search: first set req bit at or above the pointer, wrapping N-1 -> 0.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Sequencer next state; grant, m_init and rsp_valid default low so they only pulse.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    m_a_d        = m_a_q;
    m_b_d        = m_b_q;
    m_init_d     = 1'b0;
    grant_d      = '0;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d    = pick_idx;
          m_a_d    = a_bus[int'(pick_idx)*W +: W];
          m_b_d    = b_bus[int'(pick_idx)*W +: W];
          grant_d  = ONE_N << pick_idx;
          m_init_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        state_d = S_GUARD;
      end
      // One dead cycle so a done level left over from the previous operation is never taken.
      S_GUARD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) begin
          rsp_result_d = m_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = ONE_N << win_q;
          state_d      = S_RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = ONE_N << win_q;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      m_a_q        <= '0;
      m_b_q        <= '0;
      m_init_q     <= 1'b0;
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      m_a_q        <= m_a_d;
      m_b_q        <= m_b_d;
      m_init_q     <= m_init_d;
      grant_q      <= grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign m_a        = m_a_q;
  assign m_b        = m_b_q;
  assign m_init     = m_init_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios then randomized operations.
// The multiplier is modelled here with a programmable latency and holds done high between ops.
// Expected winners come from a pointer-order search; expected products from plain arithmetic.
module tb_mult_arbiter;

  localparam int N       = 4;
  localparam int W       = 3;
  localparam int TIMEOUT = 32;
  localparam int PW      = 2 * W;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N*W-1:0]  a_bus = '0;
  logic [N*W-1:0]  b_bus = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_result;
  logic            rsp_err;
  logic            busy;
  logic [W-1:0]    m_a;
  logic [W-1:0]    m_b;
  logic            m_init;
  logic [PW-1:0]   m_result = '0;
  logic            m_done   = 1'b0;

  always #5 clk = ~clk;

  mult_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_bus      (a_bus),
    .b_bus      (b_bus),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_init     (m_init),
    .m_result   (m_result),
    .m_done     (m_done)
  );

  // Multiplier model: done drops one edge after init is seen (so it is still high during
  // the guard cycle), rises mm_lat edges after init, then stays high with the product.
  int            mm_lat  = 3;
  bit            mm_hang = 1'b0;
  bit            mm_act  = 1'b0;
  int            mm_k    = 0;
  logic [PW-1:0] mm_a    = '0;
  logic [PW-1:0] mm_b    = '0;

  always @(posedge clk) begin
    if (m_init) begin
      mm_act <= 1'b1;
      mm_k   <= 0;
      mm_a   <= PW'(m_a);
      mm_b   <= PW'(m_b);
    end else if (mm_act) begin
      if (mm_k == 0) m_done <= 1'b0;
      if (!mm_hang && mm_k == mm_lat - 1) begin
        m_done   <= 1'b1;
        m_result <= mm_a * mm_b;
        mm_act   <= 1'b0;
      end
      mm_k <= mm_k + 1;
    end
  end

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  int ref_ptr = 0;
  int n_cmp   = 0;
  int n_err   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      a_bus[i*W +: W] = a_arr[i];
      b_bus[i*W +: W] = b_arr[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = W'($urandom);
      b_arr[i] = W'($urandom);
    end
    drive_ops();
  endtask

  // Reference round-robin: first requesting index at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string pfx);
    check({pfx, "_grant"},      32'(grant),      0);
    check({pfx, "_rsp_valid"},  32'(rsp_valid),  0);
    check({pfx, "_rsp_result"}, 32'(rsp_result), 0);
    check({pfx, "_rsp_err"},    32'(rsp_err),    0);
    check({pfx, "_busy"},       32'(busy),       0);
    check({pfx, "_m_a"},        32'(m_a),        0);
    check({pfx, "_m_b"},        32'(m_b),        0);
    check({pfx, "_m_init"},     32'(m_init),     0);
  endtask

  // One complete operation. Called at a negedge; returns at the negedge of the response cycle.
  // glat: negedges from applying req to seeing grant (1 from idle, 2 right after a response).
  task automatic run_op(input logic [N-1:0] r, input bit drop, input bit to,
                        input int lat, input int glat, output int w);
    int t;
    logic [PW-1:0] exp_p;
    logic [W-1:0]  ea, eb;
    mm_lat  = lat;
    mm_hang = to;
    req     = r;
    drive_ops();
    w = pick(r, ref_ptr);
    if (w < 0) w = 0;
    ea    = a_arr[w];
    eb    = b_arr[w];
    exp_p = to ? '0 : PW'(ea) * PW'(eb);

    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (grant == '0 && t < 200);
    check("grant_latency", 32'(t), 32'(glat));
    check("grant_onehot", 32'(grant), 32'(1) << w);
    check("m_init_with_grant", 32'(m_init), 1);
    check("busy_in_init", 32'(busy), 1);
    check("m_a_latched", 32'(m_a), 32'(ea));
    check("m_b_latched", 32'(m_b), 32'(eb));

    // After grant the requester may drop req and change its operands freely.
    if (drop) req[w] = 1'b0;
    a_arr[w] = W'($urandom);
    b_arr[w] = W'($urandom);
    drive_ops();

    @(negedge clk);
    check("grant_one_cycle", 32'(grant), 0);
    check("m_init_one_cycle", 32'(m_init), 0);

    t = 1;
    while (rsp_valid == '0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rsp_latency", 32'(t), to ? 32'(TIMEOUT + 2) : 32'(lat + 2));
    check("rsp_valid_onehot", 32'(rsp_valid), 32'(1) << w);
    check("rsp_result", 32'(rsp_result), 32'(exp_p));
    check("rsp_err", 32'(rsp_err), 32'(to));
    check("m_a_stable", 32'(m_a), 32'(ea));
    check("busy_in_resp", 32'(busy), 1);
    ref_ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    int t;
    bit seen;
    logic [N-1:0] r0;

    // Reset with random requests pending: everything quiet, first grant to lowest bit.
    r0 = N'($urandom_range(1, (1 << N) - 1));
    req = r0;
    rand_ops();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    run_op(r0, 1'b1, 1'b0, 3, 1, w);
    for (int i = 0; i < N; i++) begin
      if (r0[i]) begin
        check("reset_first_lowest", 32'(w), 32'(i));
        break;
      end
    end

    // Single operation 3*5.
    a_arr[0] = 3'd3; b_arr[0] = 3'd5;
    run_op(4'b0001, 1'b1, 1'b0, 3, 2, w);
    check("single_result_15", 32'(rsp_result), 15);

    // Move the pointer back to 0 via requester 3.
    a_arr[3] = 3'd2; b_arr[3] = 3'd2;
    run_op(4'b1000, 1'b1, 1'b0, 2, 2, w);

    // Full contention with stale done held high between operations.
    a_arr[0] = 3'd7; b_arr[0] = 3'd7;
    a_arr[1] = 3'd2; b_arr[1] = 3'd3;
    a_arr[2] = 3'd0; b_arr[2] = 3'd5;
    a_arr[3] = 3'd6; b_arr[3] = 3'd4;
    run_op(4'b1111, 1'b1, 1'b0, 3, 2, w);
    check("cont_order0", 32'(w), 0);
    check("cont_result49", 32'(rsp_result), 49);
    run_op(4'b1110, 1'b1, 1'b0, 3, 2, w);
    check("cont_order1", 32'(w), 1);
    check("cont_result6", 32'(rsp_result), 6);
    run_op(4'b1100, 1'b1, 1'b0, 3, 2, w);
    check("cont_order2", 32'(w), 2);
    check("cont_result0", 32'(rsp_result), 0);
    run_op(4'b1000, 1'b1, 1'b0, 3, 2, w);
    check("cont_order3", 32'(w), 3);
    check("cont_result24", 32'(rsp_result), 24);

    // Fairness with wrap: req 1010 held continuously.
    run_op(4'b1010, 1'b0, 1'b0, 2, 2, w);
    check("fair_1st", 32'(w), 1);
    run_op(4'b1010, 1'b0, 1'b0, 2, 2, w);
    check("fair_2nd", 32'(w), 3);
    run_op(4'b1010, 1'b0, 1'b0, 2, 2, w);
    check("fair_3rd", 32'(w), 1);
    run_op(4'b1010, 1'b0, 1'b0, 2, 2, w);
    check("fair_4th", 32'(w), 3);

    // Timeout, then a normal operation.
    run_op(4'b0001, 1'b1, 1'b1, 3, 2, w);
    run_op(4'b0010, 1'b1, 1'b0, 4, 2, w);

    // Reset in the middle of a WAIT.
    mm_hang  = 1'b1;
    a_arr[0] = 3'd5; b_arr[0] = 3'd5;
    drive_ops();
    req = 4'b0001;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (grant == '0 && t < 50);
    check("midrst_grant", 32'(grant), 1);
    req = '0;
    repeat (6) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
    end
    rst_n   = 1'b1;
    ref_ptr = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("midrst_no_rsp", 32'(seen), 0);
    a_arr[2] = 3'd6; b_arr[2] = 3'd7;
    run_op(4'b0100, 1'b1, 1'b0, 3, 1, w);
    check("midrst_winner2", 32'(w), 2);
    check("midrst_result42", 32'(rsp_result), 42);

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      rand_ops();
      run_op(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), $urandom_range(2, 6), 2, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `mult` shift-add multiplier instance among N requesters.
- Accepts operand pairs from requesters and latches the winner's operands onto the multiplier.
- Pulses the multiplier's `init`, waits for `done`, and returns the product to the winner with a one-cycle valid pulse.
- Sits between the multiplier and its client blocks; the multiplier connects only to this block.

Parameters:
- N, 4, number of requesters (2..8).
- W, 3, operand width; product width is 2W.
- TIMEOUT, 32, maximum cycles in WAIT before the operation is aborted with error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level; bit i held high until grant[i].
- a_bus  input  N*W  operand A; requester i on bits [i*W +: W].
- b_bus  input  N*W  operand B; requester i on bits [i*W +: W].
- grant  output  N  one-hot, one-cycle pulse: operands of requester i have been captured.
- rsp_valid  output  N  one-hot, one-cycle pulse: rsp_result/rsp_err belong to requester i.
- rsp_result  output  2W  product; valid only while rsp_valid != 0.
- rsp_err  output  1  timeout flag; valid only while rsp_valid != 0.
- busy  output  1  high in every state except IDLE.
- m_a  output  W  operand A to the multiplier; registered, stable from INIT through RESP.
- m_b  output  W  operand B to the multiplier; registered, stable from INIT through RESP.
- m_init  output  1  multiplier start; exactly one-cycle pulse per operation.
- m_result  input  2W  multiplier product.
- m_done  input  1  multiplier completion level.

Behaviour:
- All outputs are registered.
- Asynchronous reset (rst_n=0) immediately clears:
  - grant, rsp_valid, rsp_result, rsp_err, busy, m_a, m_b, m_init to 0;
  - FSM to IDLE, round-robin pointer to 0, WAIT counter to 0.
- FSM states: IDLE, INIT, GUARD, WAIT, RESP.
- IDLE:
  - If req != 0, choose winner w = first set bit of req searching upward from the pointer, wrapping N-1 -> 0.
  - Latch a_bus/b_bus slice w into m_a/m_b and go to INIT.
  - If req == 0, stay in IDLE.
- INIT (1 cycle): grant[w]=1, m_init=1, busy=1; go to GUARD.
- GUARD (1 cycle): m_init=0; m_done is ignored so a stale done from the previous operation is never accepted; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If m_done=1: capture m_result into rsp_result, set rsp_err=0, go to RESP.
  - Else if counter reaches TIMEOUT: set rsp_result=0, rsp_err=1, go to RESP.
- RESP (1 cycle):
  - rsp_valid[w]=1.
  - Pointer <= (w+1) mod N.
  - Clear counter; go to IDLE.
- Latency:
  - req to grant: 2 cycles (IDLE sample, then INIT).
  - grant to rsp_valid: 2 + multiplier latency + 1 cycles.
  - Back-to-back: the next operation's INIT occurs no earlier than 2 cycles after RESP.
- Handshake:
  - Requester may drop req or change operands any time after grant; the captured operation completes and is always answered.
  - req dropped before grant: withdrawn, no response issued.
  - req still high in the IDLE cycle after its own RESP: treated as a new request, subject to round-robin (no back-to-back win while another requester waits).
- Arithmetic: the product is passed unmodified (2W bits); no truncation or saturation.
- Simultaneous requests: resolved purely by pointer order. Every requester is granted within N operations of asserting req.
- Reset mid-operation: the operation is discarded with no rsp_valid; m_init drops asynchronously.
- req changes during non-IDLE states are ignored until IDLE.

Test Plan:
- Reset: hold rst_n=0 with random req -> all outputs 0; release -> first grant goes to the lowest set req bit.
- Single op: req=0001, a0=3, b0=5 -> grant=0001 for one cycle together with one m_init pulse, m_a=3, m_b=5; rsp_valid=0001 with rsp_result=15, rsp_err=0.
- Stale done and full contention:
  - Bench multiplier model holds m_done high between ops.
  - req=1111 with (a,b) pairs (7,7), (2,3), (0,5), (6,4) for requesters 0..3.
  - Required: grants in order 0, 1, 2, 3; results 49, 6, 0, 24; no result taken from a stale done.
- Fairness with wrap: req=1010 held continuously -> grants alternate 1, 3, 1, 3; requester 3's win is followed by requester 1.
- Timeout: model never asserts m_done, TIMEOUT=32 -> rsp_valid after 32 WAIT cycles with rsp_err=1, rsp_result=0; the next request then completes normally.
- Mid-op reset: drop rst_n during WAIT of a req0 operation -> outputs 0 immediately and no rsp_valid. After release, req=0100, a=6, b=7 -> grant=0100, result 42.
